// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings for the multicycle control unit (CU_MEM_WAIT_EN adds wait states)
package cu_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_BRANCH,
        S_LUI,
        S_AUIPC,
        S_HALT
`ifdef CU_MEM_WAIT_EN
        ,
        S_FETCH_W,
        S_MEMREAD_W
`endif
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    // Which funct interpretation the ALU decoder applies in the current state
    typedef enum logic [1:0] {
        CLASS_ADD    = 2'd0,
        CLASS_RTYPE  = 2'd1,
        CLASS_ITYPE  = 2'd2,
        CLASS_BRANCH = 2'd3
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format implied by the opcode; I-format for anything without one
    function automatic logic [2:0] imm_type(input logic [6:0] op);
        case (op)
            OP_STORE:         imm_type = IMM_S;
            OP_BRANCH:        imm_type = IMM_B;
            OP_JAL:           imm_type = IMM_J;
            OP_LUI, OP_AUIPC: imm_type = IMM_U;
            default:          imm_type = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// rtl/control_unit_alu_decoder.sv - maps op class and funct fields to an ALU operation
module alu_decoder
    import cu_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_ctrl_t  alu_control
);

    // Branches compare via SUB/SLT/SLTU; R/I types follow funct3, with funct7[5] picking SUB/SRA
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_class)
            CLASS_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            CLASS_RTYPE, CLASS_ITYPE: begin
                case (funct3)
                    3'b000:  alu_control = (alu_class == CLASS_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV32I control FSM (CU_MEM_WAIT_EN adds fetch/load wait states)
module control_unit
    import cu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal
);

    state_t     state;
    logic       illegal_q;
    alu_class_t alu_class;
    alu_ctrl_t  alu_op;
    logic       pc_write_en, mem_write_en, ir_write_en, reg_write_en;
    logic       branch_invert;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // bne/blt/bltu take the branch when the compare result is non-zero
    assign branch_invert = funct3[2] ^ funct3[0];

    // State sequencing and the sticky illegal-opcode flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state)
`ifdef CU_MEM_WAIT_EN
                S_FETCH:     state <= S_FETCH_W;
                S_FETCH_W:   state <= S_DECODE;
                S_MEMREAD:   state <= S_MEMREAD_W;
                S_MEMREAD_W: state <= S_MEMWB;
`else
                S_FETCH:     state <= S_DECODE;
                S_MEMREAD:   state <= S_MEMWB;
`endif
                S_DECODE: begin
                    case (op_code)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_LUI:            state <= S_LUI;
                        OP_AUIPC:          state <= S_AUIPC;
                        default: begin
                            illegal_q <= 1'b1;
                            state     <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                        end
                    endcase
                end
                S_MEMADR:   state <= (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_JALR:     state <= S_JALR_PC;
                S_JALR_PC:  state <= S_ALUWB;
                S_BRANCH:   state <= S_FETCH;
                S_LUI:      state <= S_ALUWB;
                S_AUIPC:    state <= S_ALUWB;
                S_HALT:     state <= S_HALT;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the current state; unlisted states leave everything idle
    always_comb begin
        pc_write_en  = 1'b0;
        mem_write_en = 1'b0;
        ir_write_en  = 1'b0;
        reg_write_en = 1'b0;
        adr_src      = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_class    = CLASS_ADD;
        case (state)
`ifdef CU_MEM_WAIT_EN
            S_FETCH_W: begin
`else
            S_FETCH: begin
`endif
                ir_write_en = 1'b1;
                pc_write_en = 1'b1;
                alu_src_b   = SRC_B_FOUR;
                result_src  = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
`ifdef CU_MEM_WAIT_EN
            S_MEMREAD, S_MEMREAD_W: adr_src = 1'b1;
`else
            S_MEMREAD: adr_src = 1'b1;
`endif
            S_MEMWB: begin
                result_src   = RES_MEM;
                reg_write_en = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write_en = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_class = CLASS_RTYPE;
            end
            S_EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_class = CLASS_ITYPE;
            end
            S_ALUWB: reg_write_en = 1'b1;
            S_JAL, S_JALR_PC: begin
                alu_src_a   = SRC_A_OLDPC;
                alu_src_b   = SRC_B_FOUR;
                pc_write_en = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = SRC_A_RS1;
                alu_class   = CLASS_BRANCH;
                pc_write_en = Zero ^ branch_invert;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .alu_control (alu_op)
    );

    // Reset overrides the state decode so no write fires while reset is held
    assign pc_write    = pc_write_en  & ~reset;
    assign mem_write   = mem_write_en & ~reset;
    assign IR_write    = ir_write_en  & ~reset;
    assign reg_write   = reg_write_en & ~reset;
    assign illegal     = illegal_q;
    assign imm_src     = imm_type(op_code);
    assign alu_control = alu_op;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit (honours CU_MEM_WAIT_EN)
module tb_control_unit;
    import cu_pkg::*;

    localparam int X = -1;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       pc_write, adr_src, mem_write, IR_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .op_code     (op_code),
        .funct3      (funct3),
        .funct7      (funct7),
        .Zero        (Zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .IR_write    (IR_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int pcw, adr, memw, irw, regw, rs, a, b, imm, alu, ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int ADD  = 0;
    localparam int SUB  = 1;
    localparam int SLT  = 5;
    localparam int SLTU = 6;
    localparam int SRA  = 9;

    task automatic chk(input string nm, input string fld, input int act, input int exp_v);
        if (exp_v >= 0) begin
            n_tests++;
            if (act != exp_v) begin
                n_fail++;
                $display("FAIL %s %s: got %0d expected %0d", nm, fld, act, exp_v);
            end
        end
    endtask

    exp_t cur;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk(cur.nm, "pc_write",    int'(pc_write),    cur.pcw);
            chk(cur.nm, "adr_src",     int'(adr_src),     cur.adr);
            chk(cur.nm, "mem_write",   int'(mem_write),   cur.memw);
            chk(cur.nm, "IR_write",    int'(IR_write),    cur.irw);
            chk(cur.nm, "reg_write",   int'(reg_write),   cur.regw);
            chk(cur.nm, "result_src",  int'(result_src),  cur.rs);
            chk(cur.nm, "alu_src_a",   int'(alu_src_a),   cur.a);
            chk(cur.nm, "alu_src_b",   int'(alu_src_b),   cur.b);
            chk(cur.nm, "imm_src",     int'(imm_src),     cur.imm);
            chk(cur.nm, "alu_control", int'(alu_control), cur.alu);
            chk(cur.nm, "illegal",     int'(illegal),     cur.ill);
        end
    end

    task automatic step(input string nm, input int pcw, adr, memw, irw, regw, rs, a, b, imm, alu, ill);
        exp_t e;
        e.nm = nm; e.pcw = pcw; e.adr = adr; e.memw = memw; e.irw = irw; e.regw = regw;
        e.rs = rs; e.a = a; e.b = b; e.imm = imm; e.alu = alu; e.ill = ill;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [31:0] ins);
        op_code = ins[6:0];
        funct3  = ins[14:12];
        funct7  = ins[31:25];
    endtask

    task automatic do_fetch(input string nm);
`ifdef CU_MEM_WAIT_EN
        step({nm, ":fetch"}, 0, 0, 0, 0, 0, X, X, X, X, X, 0);
`endif
        step({nm, ":fetch"}, 1, 0, 0, 1, 0, 2, 0, 2, X, ADD, 0);
    endtask

    task automatic do_decode(input string nm, input int imm);
        step({nm, ":decode"}, 0, X, 0, 0, 0, X, 1, 1, imm, ADD, 0);
    endtask

    task automatic aluwb(input string nm);
        step({nm, ":aluwb"}, 0, X, 0, 0, 1, 0, X, X, X, X, 0);
    endtask

    task automatic run_r(input string nm, input logic [31:0] ins, input int alu);
        load_instr(ins);
        do_fetch(nm);
        do_decode(nm, X);
        step({nm, ":execr"}, 0, X, 0, 0, 0, X, 2, 0, X, alu, 0);
        aluwb(nm);
    endtask

    task automatic run_i(input string nm, input logic [31:0] ins, input int alu);
        load_instr(ins);
        do_fetch(nm);
        do_decode(nm, 0);
        step({nm, ":execi"}, 0, X, 0, 0, 0, X, 2, 1, X, alu, 0);
        aluwb(nm);
    endtask

    task automatic run_branch(input string nm, input logic [31:0] ins, input logic z, input int pcw, input int alu);
        load_instr(ins);
        Zero = z;
        do_fetch(nm);
        do_decode(nm, 2);
        step({nm, ":branch"}, pcw, X, 0, 0, 0, 0, 2, 0, X, alu, 0);
        Zero = 1'b0;
    endtask

    task automatic mem_front(input string nm, input logic [31:0] ins, input int imm);
        load_instr(ins);
        do_fetch(nm);
        do_decode(nm, imm);
        step({nm, ":memadr"}, 0, X, 0, 0, 0, X, 2, 1, X, ADD, 0);
    endtask

    task automatic run_load(input string nm, input logic [31:0] ins);
        mem_front(nm, ins, 0);
        step({nm, ":memread"}, 0, 1, 0, 0, 0, 0, X, X, X, X, 0);
`ifdef CU_MEM_WAIT_EN
        step({nm, ":memread_w"}, 0, 1, 0, 0, 0, 0, X, X, X, X, 0);
`endif
        step({nm, ":memwb"}, 0, X, 0, 0, 1, 1, X, X, X, X, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        Zero  = 1'b0;
        load_instr(32'h002081B3);
        @(posedge clk);
        #1;
        step("reset", 0, X, 0, 0, 0, X, X, X, X, X, 0);
        reset = 1'b0;

        run_r("add", 32'h002081B3, ADD);
        run_r("sub", 32'h402081B3, SUB);
        run_i("srai", 32'h4020D193, SRA);
        run_i("addi_f7", 32'h40008193, ADD);

        run_branch("beq_z1", 32'h00208463, 1'b1, 1, SUB);
        run_branch("beq_z0", 32'h00208463, 1'b0, 0, SUB);
        run_branch("bne_z0", 32'h00209463, 1'b0, 1, SUB);
        run_branch("blt_z1", 32'h0020C463, 1'b1, 0, SLT);
        run_branch("bgeu_z1", 32'h0020F463, 1'b1, 1, SLTU);

        run_load("lw", 32'h0000A183);

        mem_front("sw", 32'h0030A023, 1);
        step("sw:memwrite", 0, 1, 1, 0, 0, 0, X, X, X, X, 0);

        load_instr(32'h008000EF);
        do_fetch("jal");
        do_decode("jal", 3);
        step("jal:jal", 1, X, 0, 0, 0, 0, 1, 2, X, ADD, 0);
        aluwb("jal");

        load_instr(32'h000080E7);
        do_fetch("jalr");
        do_decode("jalr", 0);
        step("jalr:jalr", 0, X, 0, 0, 0, X, 2, 1, X, ADD, 0);
        step("jalr:jalr_pc", 1, X, 0, 0, 0, 0, 1, 2, X, ADD, 0);
        aluwb("jalr");

        load_instr(32'h123451B7);
        do_fetch("lui");
        do_decode("lui", 4);
        step("lui:lui", 0, X, 0, 0, 0, X, 3, 1, X, ADD, 0);
        aluwb("lui");

        load_instr(32'h00001197);
        do_fetch("auipc");
        do_decode("auipc", 4);
        step("auipc:auipc", 0, X, 0, 0, 0, X, 1, 1, X, ADD, 0);
        aluwb("auipc");

        mem_front("sw_rst", 32'h0030A023, 1);
        reset = 1'b1;
        step("sw_rst:reset_mid", 0, X, 0, 0, 0, X, X, X, X, X, 0);
        reset = 1'b0;
        run_r("add_after_rst", 32'h002081B3, ADD);

        load_instr(32'h00000000);
        do_fetch("illegal");
        do_decode("illegal", X);
        for (int i = 0; i < 20; i++)
            step("halt", 0, X, 0, 0, 0, X, X, X, X, X, 1);
        reset = 1'b1;
        step("halt:reset", 0, X, 0, 0, 0, X, X, X, X, X, 0);
        reset = 1'b0;
        run_load("lw_after_halt", 32'h0000A183);

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
